tbt_matrix_streamer: RTL and testbench



---
 rtl/tbt_pkg.sv | 31 +++
 rtl/tbt_word_serializer.sv | 58 +++++
 rtl/tbt_matrix_streamer.sv | 181 ++++++++++++++++++
 tb/tb_tbt_matrix_streamer.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tbt_pkg.sv
// ============================================================================
//  Module      : tbt_pkg
//  Description : Shared widths, state encoding and word-select helper for the
//                2x2 FP32 matrix streamer family.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tbt_pkg;

    localparam int WORD_W = 32;
    localparam int N_ELEM = 4;
    localparam int MAT_W  = WORD_W * N_ELEM;

    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_ACK   = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    // Result words leave MSB-first: index 0 selects [127:96] (r00).
    function automatic logic [WORD_W-1:0] mat_word(input logic [MAT_W-1:0] m,
                                                   input logic [1:0]       idx);
        return m[(N_ELEM - 1 - int'(idx)) * WORD_W +: WORD_W];
    endfunction

endpackage

`default_nettype wire

// File: rtl/tbt_word_serializer.sv
// ============================================================================
//  Module      : tbt_word_serializer
//  Description : Loads a 128-bit matrix and shifts it out as four 32-bit
//                words over valid/ready, MSB word first, with out_last on
//                the fourth word.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tbt_word_serializer
    import tbt_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [MAT_W-1:0]  load_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last
);

    localparam logic [1:0] LAST_IDX = 2'(N_ELEM - 1);

    logic [MAT_W-1:0] r_data;
    logic [1:0]       r_idx;
    logic             r_valid;

    // Capture a new matrix when idle; step one word per accepted beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data  <= '0;
            r_idx   <= 2'd0;
            r_valid <= 1'b0;
        end else if (load && !r_valid) begin
            r_data  <= load_data;
            r_idx   <= 2'd0;
            r_valid <= 1'b1;
        end else if (r_valid && out_ready) begin
            if (r_idx == LAST_IDX) begin
                r_idx   <= 2'd0;
                r_valid <= 1'b0;
            end else begin
                r_idx <= r_idx + 2'd1;
            end
        end
    end

    // Data is held stable while stalled; zero when nothing is offered.
    always_comb begin
        out_valid = r_valid;
        out_data  = r_valid ? mat_word(r_data, r_idx) : '0;
        out_last  = r_valid && (r_idx == LAST_IDX);
    end

endmodule

`default_nettype wire

// File: rtl/tbt_matrix_streamer.sv
// ============================================================================
//  Module      : tbt_matrix_streamer
//  Description : Initiator front end for the 2x2 FP32 matrix adder. Packs
//                eight input words into A/B, strobes the engine, completes
//                the result_ready/result_ack handshake and streams the four
//                result words back out.
//  Options     : TMS_TIMEOUT_EN - watchdog over S_WAIT/S_ACK, err pulse and
//                return to S_LOAD after TIMEOUT_CYCLES cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tbt_matrix_streamer
    import tbt_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last,
    output logic              A_stb,
    output logic              B_stb,
    output logic [MAT_W-1:0]  A,
    output logic [MAT_W-1:0]  B,
    input  logic              result_ready,
    output logic              result_ack,
    input  logic [MAT_W-1:0]  result,
    output logic              busy,
    output logic              err
);

    localparam logic [2:0] LAST_SLOT = 3'(2 * N_ELEM - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_cnt;
    logic [MAT_W-1:0] r_a;
    logic [MAT_W-1:0] r_b;
    logic [MAT_W-1:0] r_result;
    logic             w_in_fire;
    logic             w_ser_load;
    logic             w_drain_done;
    logic             w_timeout;

`ifdef TMS_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TMR_W-1:0] r_timer;

    assign w_timeout = ((r_state == S_WAIT) || (r_state == S_ACK)) &&
                       (r_timer == TMR_W'(TIMEOUT_CYCLES - 1));

    // Watchdog counts only while the engine owns the transaction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_timer <= '0;
        end else if (((r_state == S_WAIT) || (r_state == S_ACK)) && !w_timeout) begin
            r_timer <= r_timer + TMR_W'(1);
        end else begin
            r_timer <= '0;
        end
    end
`else
    logic [31:0] w_unused_timeout;
    assign w_unused_timeout = 32'(TIMEOUT_CYCLES);
    assign w_timeout        = 1'b0;
`endif

    assign w_in_fire    = in_valid && in_ready;
    assign w_drain_done = (r_state == S_DRAIN) && out_valid && out_ready && out_last;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-state handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        A_stb       = 1'b0;
        B_stb       = 1'b0;
        result_ack  = 1'b0;
        w_ser_load  = 1'b0;
        case (r_state)
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && (r_cnt == LAST_SLOT)) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                A_stb       = 1'b1;
                B_stb       = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (w_timeout) begin
                    w_state_nxt = S_LOAD;
                end else if (result_ready) begin
                    w_state_nxt = S_ACK;
                end
            end
            S_ACK: begin
                // Hold ack until the engine drops result_ready, so it is idle
                // again before the next strobe can be issued.
                if (w_timeout) begin
                    w_state_nxt = S_LOAD;
                end else begin
                    result_ack = 1'b1;
                    if (!result_ready) begin
                        w_ser_load  = 1'b1;
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (w_drain_done) begin
                    w_state_nxt = S_LOAD;
                end
            end
            default: begin
                w_state_nxt = S_LOAD;
            end
        endcase
    end

    // Operand slots: words 0-3 fill A, 4-7 fill B, element k at bits k*32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= 3'd0;
            r_a   <= '0;
            r_b   <= '0;
        end else if (w_in_fire) begin
            if (r_cnt[2]) begin
                r_b[int'(r_cnt[1:0]) * WORD_W +: WORD_W] <= in_data;
            end else begin
                r_a[int'(r_cnt[1:0]) * WORD_W +: WORD_W] <= in_data;
            end
            r_cnt <= (r_cnt == LAST_SLOT) ? 3'd0 : r_cnt + 3'd1;
        end
    end

    // Result capture on the first result_ready seen in S_WAIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_result <= '0;
        end else if ((r_state == S_WAIT) && result_ready && !w_timeout) begin
            r_result <= result;
        end
    end

    tbt_word_serializer u_ser (
        .clk       (clk),
        .reset     (reset),
        .load      (w_ser_load),
        .load_data (r_result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    assign A    = r_a;
    assign B    = r_b;
    assign busy = !((r_state == S_LOAD) && (r_cnt == 3'd0));
    assign err  = w_timeout;

endmodule

`default_nettype wire

// File: tb/tb_tbt_matrix_streamer.sv
// ============================================================================
//  Module      : tb_tbt_matrix_streamer
//  Description : Scoreboard bench for tbt_matrix_streamer with a behavioural
//                engine model returning a per-transaction canned result.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_tbt_matrix_streamer;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         out_last;
    logic         A_stb;
    logic         B_stb;
    logic [127:0] A;
    logic [127:0] B;
    logic         result_ready;
    logic         result_ack;
    logic [127:0] result;
    logic         busy;
    logic         err;

    always #5 clk = ~clk;

    tbt_matrix_streamer #(.TIMEOUT_CYCLES(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .A_stb        (A_stb),
        .B_stb        (B_stb),
        .A            (A),
        .B            (B),
        .result_ready (result_ready),
        .result_ack   (result_ack),
        .result       (result),
        .busy         (busy),
        .err          (err)
    );

    typedef struct { logic [127:0] a; logic [127:0] b; } ab_t;
    typedef struct { logic [31:0] d; logic last; } ow_t;
    typedef struct { logic [127:0] res; int hold; bit dead; } eng_t;

    ab_t  ab_q[$];
    ow_t  out_q[$];
    eng_t eng_q[$];

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Cycle counter for latency measurements.
    int cyc = 0;
    always @(posedge clk) cyc++;

    // Engine model: registered response, samples on negedge, drives after posedge.
    int   e_st = 0, e_lat = 0, e_hold = 0, stb_busy = 0;
    eng_t e_cur;
    logic s_stb, s_ack, s_rst;
    initial begin
        result_ready = 1'b0;
        result       = '0;
    end
    always begin
        @(negedge clk);
        s_stb = A_stb;
        s_ack = result_ack;
        s_rst = reset;
        @(posedge clk);
        #1;
        if (!s_rst) begin
            e_st = 0;
            result_ready = 1'b0;
        end else begin
            if (e_st != 0 && s_stb) stb_busy++;
            case (e_st)
                0: if (s_stb) begin
                    if (eng_q.size() > 0) e_cur = eng_q.pop_front();
                    else begin e_cur.res = '0; e_cur.hold = 0; e_cur.dead = 1'b0; end
                    e_lat = 2;
                    e_st  = 1;
                end
                1: if (!e_cur.dead) begin
                    if (e_lat == 0) begin
                        result_ready = 1'b1;
                        result       = e_cur.res;
                        e_st         = 2;
                    end else e_lat--;
                end
                2: if (s_ack) begin
                    if (e_cur.hold == 0) begin result_ready = 1'b0; e_st = 0; end
                    else begin e_hold = e_cur.hold; e_st = 3; end
                end
                default: begin
                    if (e_hold <= 1) begin result_ready = 1'b0; e_st = 0; end
                    else e_hold--;
                end
            endcase
        end
    end

    // Downstream ready: always 1, or a repeating 1-0-0-1 pattern while draining.
    bit   bp_en = 1'b0;
    int   bp_idx = 0;
    logic bp_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    initial out_ready = 1'b1;
    always @(posedge clk) begin
        #1;
        if (bp_en) begin
            if (out_valid) begin
                out_ready = bp_pat[bp_idx];
                bp_idx    = (bp_idx + 1) % 4;
            end else out_ready = 1'b0;
        end else begin
            out_ready = 1'b1;
            bp_idx    = 0;
        end
    end

    // Monitor: pops expectations whenever the DUT presents strobes or words.
    int          stb_cnt = 0, stb_cyc = 0, err_cnt = 0;
    logic        p_stall = 1'b0, p_ack = 1'b0, p_rr = 1'b0;
    logic [31:0] p_data = '0;
    always @(negedge clk) begin
        ab_t e;
        ow_t o;
        if (reset) begin
            if (A_stb || B_stb) begin
                check("stb_pair", B_stb, A_stb);
                stb_cnt++;
                stb_cyc = cyc;
                if (ab_q.size() == 0) check("unexpected_stb", 1'b1, 1'b0);
                else begin
                    e = ab_q.pop_front();
                    check("A_bus", A, e.a);
                    check("B_bus", B, e.b);
                end
            end
            if (err) err_cnt++;
            if (out_valid) check("in_ready_drain", in_ready, 1'b0);
            if (p_stall) begin
                check("stall_valid", out_valid, 1'b1);
                check("stall_data", out_data, p_data);
            end
            if (p_ack && p_rr) check("ack_hold", result_ack, 1'b1);
            if (p_ack && !p_rr) begin
                check("ack_drop", result_ack, 1'b0);
                check("out_valid_latency", out_valid, 1'b1);
            end
            if (out_valid && out_ready) begin
                if (out_q.size() == 0) check("unexpected_out", out_data, 32'h0);
                else begin
                    o = out_q.pop_front();
                    check("out_data", out_data, o.d);
                    check("out_last", out_last, o.last);
                end
            end
            p_stall = out_valid && !out_ready;
            p_data  = out_data;
            p_ack   = result_ack;
            p_rr    = result_ready;
        end else begin
            p_stall = 1'b0;
            p_ack   = 1'b0;
            p_rr    = 1'b0;
        end
    end

    task automatic send_word(input logic [31:0] w);
        int n = 0;
        in_valid = 1'b1;
        in_data  = w;
        @(negedge clk);
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = $urandom;
    endtask

    task automatic send_txn(input logic [127:0] a, input logic [127:0] b,
                            input logic [127:0] res, input int hold, input bit dead);
        ab_t  e;
        eng_t t;
        ow_t  o;
        e.a = a; e.b = b;
        ab_q.push_back(e);
        t.res = res; t.hold = hold; t.dead = dead;
        eng_q.push_back(t);
        if (!dead) begin
            for (int i = 0; i < 4; i++) begin
                o.d    = res[(3 - i) * 32 +: 32];
                o.last = (i == 3);
                out_q.push_back(o);
            end
        end
        for (int i = 0; i < 4; i++) send_word(a[i * 32 +: 32]);
        for (int i = 0; i < 4; i++) send_word(b[i * 32 +: 32]);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((out_q.size() != 0 || ab_q.size() != 0 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) check("idle_timeout", out_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_stb;
        in_valid = 1'b0;
        in_data  = '0;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_A", A, 128'h0);
        check("rst_B", B, 128'h0);
        check("rst_stb", {A_stb, B_stb}, 2'b00);
        check("rst_ack", result_ack, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;

        // Basic: 1.0 + 2.0 = 3.0 per element
        send_txn({4{32'h3F800000}}, {4{32'h40000000}}, {4{32'h40400000}}, 0, 1'b0);
        wait_idle();

        // Packing, then a back-to-back transaction held off by in_ready
        send_txn(128'h44444444_33333333_22222222_11111111,
                 128'h88888888_77777777_66666666_55555555,
                 128'hAAAA0001_AAAA0002_AAAA0003_AAAA0004, 1, 1'b0);
        bp_en = 1'b1;
        send_txn(128'h0000000D_0000000C_0000000B_0000000A,
                 128'h000000F4_000000F3_000000F2_000000F1,
                 128'hC0000001_C0000002_C0000003_C0000004, 0, 1'b0);
        wait_idle();
        bp_en = 1'b0;

        // Engine holds result_ready 3 cycles after ack
        send_txn(128'h12345678_9ABCDEF0_0F1E2D3C_4B5A6978,
                 128'h01020304_05060708_090A0B0C_0D0E0F10,
                 128'h5EED0001_5EED0002_5EED0003_5EED0004, 3, 1'b0);
        wait_idle();

        // Reset mid-load after 5 words
        for (int i = 0; i < 5; i++) send_word(32'hDEAD0000 + 32'(i));
        @(negedge clk);
        check("midload_busy", busy, 1'b1);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_busy", busy, 1'b0);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        send_txn(128'h3F800000_40000000_40400000_40800000,
                 128'h40A00000_40C00000_40E00000_41000000,
                 128'h0BADF00D_CAFEBABE_FEEDFACE_8BADBEEF, 0, 1'b0);
        wait_idle();
        exp_stb = 5;

`ifdef TMS_TIMEOUT_EN
        begin
            int n = 0;
            int err_at;
            send_txn(128'h1, 128'h2, 128'h0, 0, 1'b1);
            @(negedge clk);
            while (!err && n < 200) begin
                @(negedge clk);
                n++;
            end
            err_at = cyc;
            check("err_seen", err, 1'b1);
            check("err_latency", err_at - stb_cyc, 16);
            @(negedge clk);
            check("to_in_ready", in_ready, 1'b1);
            check("to_out_valid", out_valid, 1'b0);
            repeat (20) @(negedge clk);
            check("err_once", err_cnt, 1);
            exp_stb = 6;
        end
`else
        check("err_never", err_cnt, 0);
`endif

        check("stb_total", stb_cnt, exp_stb);
        check("stb_while_busy", stb_busy, 0);
        check("out_q_drained", out_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
